// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory subsystem port arbiter.
// Contents: arbiter FSM state encoding, master index constants and the
// default starvation limit for m0 while m1 holds a locked burst.
package mem_port_arbiter_pkg;

  // Arbiter FSM: IDLE after reset, OWNx after a plain grant to master x,
  // LOCK1 while m1 holds a locked burst.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_LOCK1 = 2'd3
  } arb_state_e;

  // Master indices as stored in the last-winner register.
  localparam logic MASTER_M0 = 1'b0;
  localparam logic MASTER_M1 = 1'b1;

  // Default number of consecutive locked m1 grants tolerated while m0 waits.
  localparam int STARVE_MAX_DEFAULT = 8;

  // Next FSM state after a grant to m1, depending on whether it asked to lock.
  function automatic arb_state_e m1_win_state(input logic lock);
    arb_state_e st;
    if (lock) begin
      st = ST_LOCK1;
    end else begin
      st = ST_OWN1;
    end
    return st;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Two-way round-robin pick.
// Ports:
//   req0, req1   in  requests from m0 / m1
//   last         in  index of the master that won the previous accepted cycle
//   gnt0, gnt1   out one-hot (or zero) combinational pick
// With both requesting, the master that did not win last time is picked;
// a sole requester is always picked.
module mem_port_arbiter_rr_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  // Round-robin selection between the two requesters.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      gnt0 = (last == MASTER_M1);
      gnt1 = (last == MASTER_M0);
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of the memory_map CPU port.
// m0 is the CPU data port, m1 the DMA/scroll engine. Grants are
// combinational (access accepted when req and gnt are both high);
// read-valid strobes are registered one cycle after an accepted read,
// matching synchronous RAM latency.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   m0_* / m1_*                     per-master req, addr, wrdata, memop, we
//   m1_lock                         m1 asks to keep ownership (burst)
//   m0_gnt, m1_gnt                  combinational grants
//   m0_rvalid, m1_rvalid            registered read-data-valid strobes
//   rddata                          shared read data (mem_rddata passthrough)
//   mem_addr/wrdata/memop/we        muxed request toward memory
//   mem_rddata                      read data from memory
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wrdata,
  input  logic [31:0] m1_wrdata,
  input  logic [2:0]  m0_memop,
  input  logic [2:0]  m1_memop,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic        m1_lock,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] rddata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wrdata,
  output logic [2:0]  mem_memop,
  output logic        mem_we,
  input  logic [31:0] mem_rddata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  // The count is compared against STARVE_MAX-1 because the current locked
  // cycle is the one that brings the run of m1 grants to STARVE_MAX.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m0_rvalid_q, m0_rvalid_d;
  logic             m1_rvalid_q, m1_rvalid_d;

  logic rr_gnt0_s, rr_gnt1_s;
  logic locked_s, starve_s;
  logic m0_gnt_s, m1_gnt_s;

  mem_port_arbiter_rr_pick u_rr_pick (
    .req0 (m0_req),
    .req1 (m1_req),
    .last (last_q),
    .gnt0 (rr_gnt0_s),
    .gnt1 (rr_gnt1_s)
  );

  // Grant decision: locked burst (with starvation relief) or round-robin.
  always_comb begin
    locked_s = (state_q == ST_LOCK1) && m1_req && m1_lock;
    starve_s = locked_s && m0_req && (cnt_q == CNT_LAST);
    m0_gnt_s = 1'b0;
    m1_gnt_s = 1'b0;
    if (!rst_n) begin
      m0_gnt_s = 1'b0;
      m1_gnt_s = 1'b0;
    end else if (locked_s) begin
      m0_gnt_s = starve_s;
      m1_gnt_s = !starve_s;
    end else begin
      m0_gnt_s = rr_gnt0_s;
      m1_gnt_s = rr_gnt1_s;
    end
  end

  // Next state, last winner, starvation count and read-valid strobes.
  // A starvation grant moves to OWN0; m1 re-enters LOCK1 on its next win.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = CNT_ZERO;
    if (m0_gnt_s) begin
      state_d = ST_OWN0;
      last_d  = MASTER_M0;
    end else if (m1_gnt_s) begin
      state_d = m1_win_state(m1_lock);
      last_d  = MASTER_M1;
    end else if (state_q == ST_LOCK1) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_q;
    end

    if (locked_s && m0_req && !starve_s) begin
      if (cnt_q == CNT_SAT) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end

    m0_rvalid_d = m0_gnt_s && !m0_we;
    m1_rvalid_d = m1_gnt_s && !m1_we;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= MASTER_M1;
      cnt_q       <= CNT_ZERO;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  // Memory-side mux: m1 only when granted, otherwise m0 fields.
  always_comb begin
    if (m1_gnt_s) begin
      mem_addr   = m1_addr;
      mem_wrdata = m1_wrdata;
      mem_memop  = m1_memop;
    end else begin
      mem_addr   = m0_addr;
      mem_wrdata = m0_wrdata;
      mem_memop  = m0_memop;
    end
    mem_we = (m0_gnt_s && m0_we) || (m1_gnt_s && m1_we);
  end

  assign m0_gnt    = m0_gnt_s;
  assign m1_gnt    = m1_gnt_s;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign rddata    = mem_rddata;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 8, meaning the maximum number of consecutive locked m1 grants while m0 waits.
REQ-002 SHALL have port clk  in  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports m0_req, m1_req  in  1  access request from CPU data port (m0) and DMA/scroll engine (m1).
REQ-005 SHALL have ports m0_addr, m1_addr, m0_wrdata, m1_wrdata  in  32  per-master address and write data.
REQ-006 SHALL have ports m0_memop, m1_memop  in  3  per-master byte/half/word op; m0_we, m1_we  in  1  write enable.
REQ-007 SHALL have port m1_lock  in  1  m1 requests back-to-back ownership (burst).
REQ-008 SHALL have ports m0_gnt, m1_gnt  out  1  combinational grant; access accepted in any cycle where req and gnt are both high.
REQ-009 SHALL have ports m0_rvalid, m1_rvalid  out  1  registered; read data valid for that master.
REQ-010 SHALL have port rddata  out  32  shared read data, passthrough of mem_rddata.
REQ-011 SHALL have ports mem_addr, mem_wrdata  out  32, mem_memop  out  3, mem_we  out  1  toward memory_map CPU port; mem_rddata  in  32.

Function
REQ-012 SHALL implement FSM states IDLE, OWN0, OWN1, LOCK1 holding the most recent winner.
REQ-013 SHALL grant the sole requester when only one master requests, in the same cycle.
REQ-014 SHALL, when both request and the FSM is not LOCK1, grant the master not granted in the previous accepted cycle (round-robin); from IDLE after reset m0 wins.
REQ-015 SHALL enter LOCK1 when m1 is accepted with m1_lock high, and keep granting m1 while m1_req and m1_lock stay high.
REQ-016 SHALL count consecutive LOCK1 cycles in which m0_req is high (saturating); when the count reaches STARVE_MAX, it SHALL grant m0 for exactly one cycle, clear the count, then return to LOCK1 if m1 still holds lock.
REQ-017 SHALL leave LOCK1 for IDLE when m1_req or m1_lock deasserts; pending m0 is then granted in the same cycle.
REQ-018 SHALL never assert m0_gnt and m1_gnt together; with no grant it SHALL drive mem_we=0 and mem_addr/wrdata/memop from m0 (don't-care).
REQ-019 SHALL mux mem_* from the granted master combinationally; mem_we is master_we AND accepted.
REQ-020 SHALL assert mX_rvalid one cycle after an accepted read (we=0) by master X, for one cycle, matching synchronous RAM latency; no rvalid after writes.
REQ-021 SHALL support back-to-back accepts every cycle; a read accepted in cycle N and another in N+1 yield rvalid in N+1 and N+2.
REQ-022 SHALL hold the last winner unchanged across idle cycles (no requests).

Reset
REQ-023 SHALL, on rst_n low, immediately force state IDLE, starvation count 0, last winner m1 (so m0 wins first), m0_rvalid=m1_rvalid=0.
REQ-024 SHALL drop any pending rvalid when reset asserts mid-access; grants are low while rst_n is low.

Structure
REQ-025 SHALL place FSM state encoding, master index constants and the STARVE_MAX default in a shared package/header used by memory subsystem blocks.
REQ-026 SHALL be a single module; a sub-module rr_pick (two-way round-robin pick given last winner) is natural.

Verification
REQ-027 Single m0 read of 0x00100000 -> m0_gnt same cycle, mem_addr=0x00100000, m0_rvalid next cycle with rddata.
REQ-028 Both request every cycle, no lock -> grants alternate m0,m1,m0,m1; never both high.
REQ-029 m1 locked burst of 20 cycles, m0_req held high, STARVE_MAX=8 -> m0 granted in cycle 9 and cycle 18, m1 in all other cycles.
REQ-030 m1 write (we=1) to 0x00300010 with m1_lock dropping same cycle, m0 pending -> mem_we=1 for m1, m0 granted next cycle, no rvalid for the write.
REQ-031 rst_n low for one cycle while m0 read is in flight -> m0_rvalid stays 0, state IDLE, next dual request granted to m0.
REQ-032 Reads accepted in consecutive cycles m0 then m1 -> m0_rvalid then m1_rvalid in the following two cycles, each one cycle wide.
